slot_mem_sequencer: RTL
=======================

# slot_mem_sequencer

Sequences slot memory accesses after mapper address translation. It latches the translated address, chip selects and write permission at the start of each CPU memory cycle. It then runs one handshake toward either the external RAM (SDRAM) controller or the on-chip SRAM (save RAM) port, and holds the CPU in wait until read data is captured or the write is committed.

## Interface
Parameters:
- ADDR_W, 27, width of translated memory address
- SRAM_AW, 18, SRAM address width (low bits of latched address)
- SRAM_LAT, 1, SRAM read latency in cycles (1..3)
- TIMEOUT, 255, max cycles waiting for ram_ack before abort (8-bit counter)

Ports:
- clk_sys  in  1  system clock; all logic on rising edge
- reset_n  in  1  synchronous, active-low reset
- cpu_req  in  1  one-cycle pulse marking start of a CPU memory cycle (mreq qualified)
- cpu_wr  in  1  1 = write cycle, 0 = read (valid with cpu_req)
- cpu_din  in  8  CPU write data (valid with cpu_req)
- map_addr  in  ADDR_W  translated address from mapper stage
- map_rnw  in  1  0 = mapper permits write
- map_ram_cs  in  1  RAM selected
- map_sram_cs  in  1  SRAM selected
- wait_n  out  1  0 = stall CPU
- data  out  8  read data to slot data mux; FF when not driving
- ram_req  out  1  level request to RAM controller
- ram_we  out  1  write strobe qualifier for ram_req
- ram_addr  out  ADDR_W  latched address
- ram_wdata  out  8  latched write data
- ram_ack  in  1  one-cycle completion from RAM controller
- ram_rdata  in  8  valid in the ram_ack cycle
- sram_ce  out  1  one-cycle SRAM access pulse
- sram_we  out  1  SRAM write enable, with sram_ce
- sram_addr  out  SRAM_AW  latched address low bits
- sram_wdata  out  8  latched write data
- sram_rdata  in  8  valid SRAM_LAT cycles after sram_ce
- timeout_err  out  1  sticky; set on RAM timeout, cleared only by reset

## Operation
- States: IDLE, RAM_WAIT, SRAM_WAIT, DONE.
- Target selection at cpu_req, with sram_cs taking priority:
  - if map_sram_cs, target is SRAM;
  - else if map_ram_cs, target is RAM;
  - else there is no target.
- Write gating: when cpu_wr=1 and map_rnw=1, the access is dropped and no request is issued.
- IDLE, cpu_req with an effective access:
  - latch the address and cpu_din;
  - go to RAM_WAIT (raise ram_req, ram_we=cpu_wr) or SRAM_WAIT (pulse sram_ce, sram_we=cpu_wr).
- IDLE, cpu_req with no target or a dropped write: stay in IDLE, no stall. For a read, data=FF.
- RAM_WAIT:
  - hold ram_req, ram_addr, ram_we and ram_wdata stable until ram_ack;
  - on ram_ack, drop ram_req, capture ram_rdata if reading, go to DONE;
  - if the counter reaches TIMEOUT without ack, drop ram_req, set timeout_err, set data=FF, go to DONE.
- SRAM_WAIT: count SRAM_LAT cycles after sram_ce, capture sram_rdata if reading, go to DONE.
- DONE: release wait, drive captured data for one cycle, return to IDLE.
- data is FF in all cycles except the DONE cycle of a read.
- cpu_req arriving while not in IDLE is ignored; the CPU is stalled, so this indicates a protocol error.
- A ram_ack in any state other than RAM_WAIT is ignored, e.g. a late ack after timeout or reset.

## Timing
- Reset values:
  - state=IDLE;
  - wait_n=1;
  - data=FF;
  - ram_req=0, ram_we=0, sram_ce=0, sram_we=0;
  - ram_addr, sram_addr, ram_wdata and sram_wdata all 0;
  - timeout_err=0;
  - timeout counter=0.
- Reset applied mid-access aborts immediately on the next edge; ram_req falls without an ack.
- wait_n is combinational: wait_n = !(state != IDLE && state != DONE) && !(cpu_req && effective access). The CPU is therefore stalled from the cpu_req cycle itself.
- RAM latency:
  - cpu_req at cycle 0;
  - ram_req high from cycle 1;
  - ack at cycle N gives DONE at N+1, with data valid and wait_n=1 at N+1.
  - Minimum is ack at cycle 1, i.e. DONE at cycle 2.
- SRAM latency: sram_ce at cycle 1, capture at cycle 1+SRAM_LAT, DONE at cycle 2+SRAM_LAT.
- Timeout counter:
  - cleared on entering RAM_WAIT;
  - increments each RAM_WAIT cycle;
  - abort when count == TIMEOUT (TIMEOUT cycles after ram_req rises);
  - no wrap.
- ram_ack in the same cycle that the count reaches TIMEOUT counts as success; timeout_err stays 0.
- Back-to-back: a cpu_req in the DONE cycle is ignored. The next accepted cpu_req is the cycle after DONE.

## Test plan
- RAM read: addr=0x0012345, ram_cs=1, ack after 3 cycles with rdata=0x5A -> ram_req high 3 cycles, wait_n low 4 cycles, data=0x5A for one cycle, then FF.
- Gated write: cpu_wr=1, map_rnw=1, ram_cs=1 -> no ram_req, no sram_ce, wait_n stays 1.
- SRAM priority write: ram_cs=1 and sram_cs=1, addr=0x3ABCD, din=0xC3, SRAM_LAT=1 -> sram_ce/sram_we pulse with sram_addr=0x3ABCD and wdata=0xC3, ram_req never rises, DONE at cycle 3.
- Timeout: RAM read, ram_ack never asserted, TIMEOUT=255 -> ram_req falls after 255 cycles, timeout_err=1, data=FF in DONE, a late ram_ack is ignored.
- Reset mid-access: reset_n=0 during RAM_WAIT -> next edge gives ram_req=0, wait_n=1, data=FF, state IDLE; a subsequent read completes normally.
- No-target read: cpu_req with no chip select -> wait_n=1 throughout, data=FF, no requests issued.

Source files
------------

// File: rtl/slot_mem_sequencer.sv
// Slot memory access sequencer: latches a translated mapper access and runs one
// handshake to the external RAM controller or the on-chip save SRAM, stalling the CPU.
module slot_mem_sequencer #(
  parameter int ADDR_W   = 27,
  parameter int SRAM_AW  = 18,
  parameter int SRAM_LAT = 1,
  parameter int TIMEOUT  = 255
) (
  input  logic                clk_sys,
  input  logic                reset_n,
  input  logic                cpu_req,
  input  logic                cpu_wr,
  input  logic [7:0]          cpu_din,
  input  logic [ADDR_W-1:0]   map_addr,
  input  logic                map_rnw,
  input  logic                map_ram_cs,
  input  logic                map_sram_cs,
  output logic                wait_n,
  output logic [7:0]          data,
  output logic                ram_req,
  output logic                ram_we,
  output logic [ADDR_W-1:0]   ram_addr,
  output logic [7:0]          ram_wdata,
  input  logic                ram_ack,
  input  logic [7:0]          ram_rdata,
  output logic                sram_ce,
  output logic                sram_we,
  output logic [SRAM_AW-1:0]  sram_addr,
  output logic [7:0]          sram_wdata,
  input  logic [7:0]          sram_rdata,
  output logic                timeout_err
);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_RAM_WAIT  = 2'd1,
    ST_SRAM_WAIT = 2'd2,
    ST_DONE      = 2'd3
  } state_t;

  localparam logic [7:0] TMO_C = 8'(TIMEOUT);
  localparam logic [7:0] LAT_C = 8'(SRAM_LAT);

  state_t              state_q, state_d;
  logic [7:0]          cnt_q, cnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [7:0]          wdata_q, wdata_d;
  logic                rd_q, rd_d;
  logic                ram_req_q, ram_req_d;
  logic                ram_we_q, ram_we_d;
  logic                sram_ce_q, sram_ce_d;
  logic                sram_we_q, sram_we_d;
  logic [7:0]          data_q, data_d;
  logic                tmo_q, tmo_d;

  logic                eff_s;
  logic                start_s;
  logic                busy_s;
  logic [7:0]          cnt_inc_s;

  // A write the mapper forbids is dropped as if no device were selected.
  assign eff_s     = (map_sram_cs || map_ram_cs) && !(cpu_wr && map_rnw);
  assign start_s   = (state_q == ST_IDLE) && cpu_req && eff_s;
  assign busy_s    = (state_q == ST_RAM_WAIT) || (state_q == ST_SRAM_WAIT);
  assign cnt_inc_s = cnt_q + 8'd1;

  assign wait_n      = !busy_s && !start_s;
  assign data        = data_q;
  assign ram_req     = ram_req_q;
  assign ram_we      = ram_we_q;
  assign ram_addr    = addr_q;
  assign ram_wdata   = wdata_q;
  assign sram_ce     = sram_ce_q;
  assign sram_we     = sram_we_q;
  assign sram_addr   = addr_q[SRAM_AW-1:0];
  assign sram_wdata  = wdata_q;
  assign timeout_err = tmo_q;

  // Next-state and registered-output logic of the access sequencer.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rd_d      = rd_q;
    ram_req_d = ram_req_q;
    ram_we_d  = ram_we_q;
    sram_ce_d = 1'b0;
    sram_we_d = 1'b0;
    data_d    = 8'hFF;
    tmo_d     = tmo_q;

    case (state_q)
      ST_IDLE: begin
        if (start_s) begin
          addr_d  = map_addr;
          wdata_d = cpu_din;
          rd_d    = !cpu_wr;
          cnt_d   = 8'd0;
          if (map_sram_cs) begin
            state_d   = ST_SRAM_WAIT;
            sram_ce_d = 1'b1;
            sram_we_d = cpu_wr;
          end else begin
            state_d   = ST_RAM_WAIT;
            ram_req_d = 1'b1;
            ram_we_d  = cpu_wr;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RAM_WAIT: begin
        cnt_d = cnt_inc_s;
        // An ack in the final counted cycle still wins over the abort.
        if (ram_ack) begin
          state_d   = ST_DONE;
          ram_req_d = 1'b0;
          ram_we_d  = 1'b0;
          data_d    = rd_q ? ram_rdata : 8'hFF;
        end else if (cnt_inc_s == TMO_C) begin
          state_d   = ST_DONE;
          ram_req_d = 1'b0;
          ram_we_d  = 1'b0;
          tmo_d     = 1'b1;
        end else begin
          state_d = ST_RAM_WAIT;
        end
      end
      ST_SRAM_WAIT: begin
        if (cnt_q == LAT_C) begin
          state_d = ST_DONE;
          data_d  = rd_q ? sram_rdata : 8'hFF;
        end else begin
          cnt_d = cnt_inc_s;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d   = ST_IDLE;
        ram_req_d = 1'b0;
        ram_we_d  = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 8'd0;
      addr_q    <= '0;
      wdata_q   <= 8'd0;
      rd_q      <= 1'b0;
      ram_req_q <= 1'b0;
      ram_we_q  <= 1'b0;
      sram_ce_q <= 1'b0;
      sram_we_q <= 1'b0;
      data_q    <= 8'hFF;
      tmo_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rd_q      <= rd_d;
      ram_req_q <= ram_req_d;
      ram_we_q  <= ram_we_d;
      sram_ce_q <= sram_ce_d;
      sram_we_q <= sram_we_d;
      data_q    <= data_d;
      tmo_q     <= tmo_d;
    end
  end

endmodule
